// File: rtl/fsk_message_keyer_pkg.sv
// Shared constants and encodings for the FSK message keyer.
package fsk_message_keyer_pkg;

    localparam int unsigned INC_WIDTH_DEF = 32;
    localparam int unsigned BYTE_W        = 8;
    localparam int unsigned BIT_CNT_W     = 3;

    // Default tuning words for a 255 MHz clock (2^32 scaled).
    localparam logic [INC_WIDTH_DEF-1:0] INC_CARRIER_DEF = 32'd1684300900; // 100.000 MHz
    localparam logic [INC_WIDTH_DEF-1:0] INC_HI_DEF      = 32'd1685564126; // 100.075 MHz
    localparam logic [INC_WIDTH_DEF-1:0] INC_LO_DEF      = 32'd1683037674; //  99.925 MHz

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } keyer_state_e;

    typedef enum logic {
        TONE_LO = 1'b0,
        TONE_HI = 1'b1
    } tone_ph_e;

endpackage

// File: rtl/fsk_message_keyer_if.sv
// Byte stream handshake into the keyer.
interface fsk_message_keyer_if;
    import fsk_message_keyer_pkg::*;

    logic [BYTE_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;

    modport master (output in_data, output in_valid, input  in_ready);
    modport slave  (input  in_data, input  in_valid, output in_ready);

endinterface

// File: rtl/fsk_message_keyer_fifo.sv
// Small synchronous byte FIFO with show-ahead read data.
module fsk_message_keyer_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             ready_o,
    output logic             empty_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             not_full_q;
    logic             do_push;
    logic             do_pop;

    // A full FIFO refuses pushes; an empty FIFO ignores pops.
    assign do_push = push_i & not_full_q;
    assign do_pop  = pop_i & (cnt_q != '0);
    assign cnt_d   = cnt_q + CNT_W'(do_push) - CNT_W'(do_pop);

    assign rdata_o = mem_q[rd_ptr_q];
    assign ready_o = not_full_q;
    assign empty_o = (cnt_q == '0);

    // Storage array; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    // Pointers, occupancy and the registered not-full flag (held low in reset).
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cnt_q      <= '0;
            not_full_q <= 1'b0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            cnt_q      <= cnt_d;
            not_full_q <= (cnt_d != CNT_W'(DEPTH));
        end
    end

endmodule

// File: rtl/fsk_message_keyer.sv
// Serialises buffered message bytes LSB-first into FSK tuning-word symbols.
module fsk_message_keyer
    import fsk_message_keyer_pkg::*;
#(
    parameter int unsigned           INC_WIDTH     = INC_WIDTH_DEF,
    parameter logic [INC_WIDTH-1:0]  INC_CARRIER   = INC_CARRIER_DEF,
    parameter logic [INC_WIDTH-1:0]  INC_HI        = INC_HI_DEF,
    parameter logic [INC_WIDTH-1:0]  INC_LO        = INC_LO_DEF,
    parameter int unsigned           SYMBOL_CYCLES = 33554432,
    parameter int unsigned           TONE_HALF     = 524288,
    parameter int unsigned           FIFO_DEPTH    = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    fsk_message_keyer_if.slave   msg,
    output logic [INC_WIDTH-1:0] incr_out,
    output logic                 key_out,
    output logic                 busy
);

    localparam int unsigned SYM_W  = $clog2(SYMBOL_CYCLES);
    localparam int unsigned TONE_W = $clog2(TONE_HALF) + 1;

    logic [BYTE_W-1:0]    fifo_rdata;
    logic                 fifo_ready;
    logic                 fifo_empty;
    logic                 pop_c;

    keyer_state_e         state_q,    state_d;
    logic [BYTE_W-1:0]    shift_q,    shift_d;
    logic [BIT_CNT_W-1:0] bit_cnt_q,  bit_cnt_d;
    logic [SYM_W-1:0]     sym_tmr_q,  sym_tmr_d;
    logic [TONE_W-1:0]    tone_tmr_q, tone_tmr_d;
    tone_ph_e             tone_ph_q,  tone_ph_d;
    logic [INC_WIDTH-1:0] incr_q,     incr_d;
    logic                 key_q,      key_d;
    logic                 busy_q,     busy_d;
    logic                 sym_end;
    logic                 load;

    fsk_message_keyer_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (BYTE_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (msg.in_valid),
        .wdata_i (msg.in_data),
        .pop_i   (pop_c),
        .rdata_o (fifo_rdata),
        .ready_o (fifo_ready),
        .empty_o (fifo_empty)
    );

    assign msg.in_ready = fifo_ready;
    assign incr_out     = incr_q;
    assign key_out      = key_q;
    assign busy         = busy_q;

    assign sym_end = (sym_tmr_q == SYM_W'(SYMBOL_CYCLES - 1));

    // Next-state for the symbol sequencer; outputs are derived from next state
    // so the registered increment matches the symbol of the cycle it appears in.
    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        bit_cnt_d  = bit_cnt_q;
        sym_tmr_d  = sym_tmr_q;
        tone_tmr_d = tone_tmr_q;
        tone_ph_d  = tone_ph_q;
        load       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                load = !fifo_empty;
            end
            ST_SEND: begin
                if (sym_end) begin
                    if (bit_cnt_q == BIT_CNT_W'(BYTE_W - 1)) begin
                        load = !fifo_empty;
                        if (fifo_empty) begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        shift_d    = shift_q >> 1;
                        bit_cnt_d  = bit_cnt_q + BIT_CNT_W'(1);
                        sym_tmr_d  = '0;
                        tone_tmr_d = '0;
                        tone_ph_d  = TONE_LO;
                    end
                end else begin
                    sym_tmr_d = sym_tmr_q + SYM_W'(1);
                    if (tone_tmr_q == TONE_W'(TONE_HALF - 1)) begin
                        tone_tmr_d = '0;
                        tone_ph_d  = (tone_ph_q == TONE_LO) ? TONE_HI : TONE_LO;
                    end else begin
                        tone_tmr_d = tone_tmr_q + TONE_W'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (load) begin
            state_d    = ST_SEND;
            shift_d    = fifo_rdata;
            bit_cnt_d  = '0;
            sym_tmr_d  = '0;
            tone_tmr_d = '0;
            tone_ph_d  = TONE_LO;
        end

        pop_c  = load;
        busy_d = (state_d == ST_SEND);
        key_d  = busy_d & shift_d[0];
        if (key_d) begin
            incr_d = (tone_ph_d == TONE_HI) ? INC_HI : INC_LO;
        end else begin
            incr_d = INC_CARRIER;
        end
    end

    // Sequencer state and registered NCO outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            shift_q    <= '0;
            bit_cnt_q  <= '0;
            sym_tmr_q  <= '0;
            tone_tmr_q <= '0;
            tone_ph_q  <= TONE_LO;
            incr_q     <= INC_CARRIER;
            key_q      <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            bit_cnt_q  <= bit_cnt_d;
            sym_tmr_q  <= sym_tmr_d;
            tone_tmr_q <= tone_tmr_d;
            tone_ph_q  <= tone_ph_d;
            incr_q     <= incr_d;
            key_q      <= key_d;
            busy_q     <= busy_d;
        end
    end

endmodule
